// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a drain interrupt.
// Define UART_PARITY_EN to add CTRL.PE and an even-parity bit after the data bits.
module uart_tx_dev #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_RESET  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        tx_out,
  output logic        IRQ
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic [DW-1:0]   cur_div;
  logic [DW-1:0]   divisor;
  logic            en;
  logic            im;
  logic            ovf;
  logic            pe_rd;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            data_wr, stat_wr, ctrl_wr, div_wr;
  logic            full, empty, busy, count_hi;
  logic            push_ok, bit_end, start_frame;
  logic [DW-1:0]   div_eff;
  logic [7:0]      head;
  logic            unused;

`ifdef UART_PARITY_EN
  logic            pe;
  logic            par;
  assign pe_rd = pe;
`else
  assign pe_rd = 1'b0;
`endif

  assign data_wr  = WE && (Addr[3:2] == 2'd0);
  assign stat_wr  = WE && (Addr[3:2] == 2'd1);
  assign ctrl_wr  = WE && (Addr[3:2] == 2'd2);
  assign div_wr   = WE && (Addr[3:2] == 2'd3);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != S_IDLE);
  assign count_hi = (count >= CW'(FIFO_DEPTH / 2));
  assign push_ok  = data_wr && !full;
  assign div_eff  = (divisor == '0) ? DW'(1) : divisor;
  assign bit_end  = (div_cnt == cur_div - DW'(1));
  assign head     = mem[rd_ptr];
  assign unused   = ^{Addr[31:4], Din[31:16]};

  // A frame may start from IDLE or straight out of the last STOP cycle (no gap).
  assign start_frame = en && !empty &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  // Serialiser FSM; the divisor is re-sampled at every bit boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      tx_out  <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      cur_div <= DW'(1);
`ifdef UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      if (bit_end || (state == S_IDLE)) begin
        div_cnt <= '0;
        cur_div <= div_eff;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (start_frame) begin
        state   <= S_START;
        tx_out  <= 1'b0;
        shreg   <= head;
        bit_cnt <= '0;
`ifdef UART_PARITY_EN
        par     <= ^head;
`endif
      end else begin
        case (state)
          S_START: if (bit_end) begin
            state  <= S_DATA;
            tx_out <= shreg[0];
          end
          S_DATA: if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              if (pe) begin
                state  <= S_PARITY;
                tx_out <= par;
              end else begin
                state  <= S_STOP;
                tx_out <= 1'b1;
              end
`else
              state  <= S_STOP;
              tx_out <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_out  <= shreg[1];
            end
          end
`ifdef UART_PARITY_EN
          S_PARITY: if (bit_end) begin
            state  <= S_STOP;
            tx_out <= 1'b1;
          end
`endif
          S_STOP: if (bit_end) begin
            state  <= S_IDLE;
            tx_out <= 1'b1;
          end
          default: begin
            state  <= S_IDLE;
            tx_out <= 1'b1;
          end
        endcase
      end
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= Din[7:0];
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)     wr_ptr <= wr_ptr + AW'(1);
      if (start_frame) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(start_frame);
    end
  end

  // Control registers, sticky overflow and the registered interrupt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en      <= 1'b0;
      im      <= 1'b0;
      divisor <= DW'(DIV_RESET);
      ovf     <= 1'b0;
      IRQ     <= 1'b0;
`ifdef UART_PARITY_EN
      pe      <= 1'b0;
`endif
    end else begin
      if (ctrl_wr) begin
        en <= Din[0];
        im <= Din[1];
`ifdef UART_PARITY_EN
        pe <= Din[2];
`endif
      end
      if (div_wr) divisor <= Din[15:0];
      if (data_wr && full)         ovf <= 1'b1;
      else if (stat_wr && Din[5])  ovf <= 1'b0;
      IRQ <= im & empty & ~busy;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      2'd1:    Dout = {26'd0, ovf, count_hi, busy, full, empty, IRQ};
      2'd2:    Dout = {29'd0, pe_rd, im, en};
      2'd3:    Dout = {16'd0, divisor};
      default: Dout = '0;
    endcase
  end

endmodule
